// File: rtl/ifetch_pkg.sv
// ifetch_pkg
// Shared definitions for the instruction-fetch controller: the FSM state
// encoding, the default memory wait limit and the NOP instruction word
// that the instruction register holds out of reset.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10,
    ABORT = 2'b11
  } state_t;

  localparam int          TIMEOUT_DEF = 15;
  localparam logic [15:0] NOP         = 16'h0000;

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if
// Instruction-memory read bus.
//   mem_req   : read request, held high for the whole request
//   mem_addr  : read address, stable while mem_req=1
//   mem_ack   : read data valid, meaningful only while mem_req=1
//   mem_rdata : instruction word returned with mem_ack
// master = fetch controller, slave = instruction memory.
interface ifetch_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (output mem_req, output mem_addr,
                  input  mem_ack, input  mem_rdata);
  modport slave  (input  mem_req, input  mem_addr,
                  output mem_ack, output mem_rdata);
endinterface

// File: rtl/ifetch_timer.sv
// ifetch_timer
// 8-bit wait counter for a pending memory request.
//   CLK  : clock
//   CLR  : asynchronous active-high reset
//   clr  : synchronous clear (wins over inc)
//   inc  : count one more wait cycle
//   term : high while the count equals TIMEOUT-1
module ifetch_timer
  import ifetch_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic CLK,
  input  logic CLR,
  input  logic clr,
  input  logic inc,
  output logic term
);

  localparam logic [7:0] TERM_VAL = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)      cnt <= 8'd0;
    else if (clr) cnt <= 8'd0;
    else if (inc) cnt <= cnt + 8'd1;
  end

  assign term = (cnt == TERM_VAL);

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl
// Instruction-fetch controller. Issues one memory read per instruction at
// the current PC, latches the returned word for decode and enables the PC
// only once decode has taken that word. A request that sees no ack for
// TIMEOUT cycles is abandoned for one cycle and reissued at the same PC.
//   CLK, CLR    : clock, asynchronous active-high reset
//   pc_i        : current PC value
//   PC_EN       : PC advance enable (HOLD and core_ready)
//   mem         : instruction-memory bus (master side)
//   core_ready  : decode accepts instr_o this cycle
//   instr_o     : latched instruction
//   instr_valid : instr_o holds an unconsumed instruction
//   fetch_err   : one-cycle pulse on a timeout abort
//   fetch_cnt   : consumed-instruction count, wraps silently
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [15:0]      pc_i,
  output logic             PC_EN,
  ifetch_if.master         mem,
  input  logic             core_ready,
  output logic [15:0]      instr_o,
  output logic             instr_valid,
  output logic             fetch_err,
  output logic [CNT_W-1:0] fetch_cnt
);

  state_t state, state_n;
  logic   timer_inc, timer_clr, timer_term;
  logic   capture, consume;

  ifetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK  (CLK),
    .CLR  (CLR),
    .clr  (timer_clr),
    .inc  (timer_inc),
    .term (timer_term)
  );

  // The PC only moves while no request is outstanding, so passing pc_i
  // straight through keeps the address stable for the whole request.
  assign mem.mem_addr = pc_i;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    mem.mem_req = 1'b0;
    PC_EN       = 1'b0;
    fetch_err   = 1'b0;
    timer_inc   = 1'b0;
    timer_clr   = 1'b0;
    capture     = 1'b0;
    consume     = 1'b0;
    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        mem.mem_req = 1'b1;
        // An ack arriving on the terminal wait cycle still completes.
        if (mem.mem_ack) begin
          capture   = 1'b1;
          timer_clr = 1'b1;
          state_n   = HOLD;
        end else if (timer_term) begin
          timer_clr = 1'b1;
          state_n   = ABORT;
        end else begin
          timer_inc = 1'b1;
        end
      end
      HOLD: begin
        PC_EN = core_ready;
        if (core_ready) begin
          consume = 1'b1;
          state_n = FETCH;
        end
      end
      ABORT: begin
        // mem_req drops for this cycle so a late ack is never sampled.
        fetch_err = 1'b1;
        state_n   = FETCH;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      instr_o     <= NOP;
      instr_valid <= 1'b0;
      fetch_cnt   <= '0;
    end else begin
      if (capture) begin
        instr_o     <= mem.mem_rdata;
        instr_valid <= 1'b1;
      end else if (consume) begin
        instr_valid <= 1'b0;
      end
      if (consume) fetch_cnt <= fetch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
module tb_ifetch_ctrl;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 4;

  logic                CLK = 1'b0;
  logic                CLR = 1'b1;
  logic [15:0]         pc_i;
  logic                PC_EN;
  logic                core_ready = 1'b0;
  logic [15:0]         instr_o;
  logic                instr_valid;
  logic                fetch_err;
  logic [TB_CNT_W-1:0] fetch_cnt;
  logic [15:0]         next_pc = 16'h0;

  ifetch_if bus ();

  ifetch_ctrl #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .pc_i        (pc_i),
    .PC_EN       (PC_EN),
    .mem         (bus),
    .core_ready  (core_ready),
    .instr_o     (instr_o),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err),
    .fetch_cnt   (fetch_cnt)
  );

  always #5 CLK = ~CLK;

  // PC block: loads next_pc whenever the controller enables it.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)        pc_i <= 16'h0;
    else if (PC_EN) pc_i <= next_pc;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model, in terms of what the controller is doing right now.
  bit          m_boot;     // first cycle after reset, nothing happening yet
  bit          m_have;     // an instruction is waiting for decode
  bit          m_abort;    // the abandoned-request cycle
  int          m_waited;   // no-ack cycles in the current request
  int          m_cnt;      // instructions consumed, modulo 2^CNT_W
  logic [15:0] m_instr;
  logic [15:0] m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_have = 0; m_abort = 0; m_waited = 0;
    m_cnt = 0; m_instr = 16'h0000; m_pc = 16'h0000;
  endtask

  task automatic check_reset();
    check("rst_mem_req", 32'(bus.mem_req), 32'(0));
    check("rst_pc_en", 32'(PC_EN), 32'(0));
    check("rst_instr_o", 32'(instr_o), 32'(0));
    check("rst_instr_valid", 32'(instr_valid), 32'(0));
    check("rst_fetch_err", 32'(fetch_err), 32'(0));
    check("rst_fetch_cnt", 32'(fetch_cnt), 32'(0));
  endtask

  // One clock cycle: drive inputs at the falling edge, check, then advance.
  task automatic step(input logic ack, input logic [15:0] rd, input logic rdy,
                      input logic [15:0] npc);
    bit req_exp;
    bus.mem_ack = ack; bus.mem_rdata = rd; core_ready = rdy; next_pc = npc;
    #1;
    req_exp = !m_boot && !m_have && !m_abort;
    check("mem_req", 32'(bus.mem_req), 32'(req_exp));
    if (req_exp) check("mem_addr", 32'(bus.mem_addr), 32'(m_pc));
    check("pc_en", 32'(PC_EN), 32'(m_have && rdy));
    check("fetch_err", 32'(fetch_err), 32'(m_abort));
    check("instr_o", 32'(instr_o), 32'(m_instr));
    check("instr_valid", 32'(instr_valid), 32'(m_have));
    check("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
    check("pc_i", 32'(pc_i), 32'(m_pc));
    @(posedge CLK);
    if (m_boot) begin
      m_boot = 0;
    end else if (m_abort) begin
      m_abort = 0;
    end else if (m_have) begin
      if (rdy) begin
        m_have = 0;
        m_cnt  = (m_cnt + 1) % (1 << TB_CNT_W);
        m_pc   = npc;
      end
    end else if (ack) begin
      m_have = 1; m_instr = rd; m_waited = 0;
    end else if (m_waited + 1 == TB_TIMEOUT) begin
      m_abort = 1; m_waited = 0;
    end else begin
      m_waited++;
    end
    @(negedge CLK);
  endtask

  initial begin
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;
    model_reset();
    @(negedge CLK); @(negedge CLK);
    check_reset();
    CLR = 1'b0;

    // Sequential stream, immediate acks, decode always ready.
    step(0, 16'h0, 1, m_pc + 16'd1);
    for (int i = 0; i < 8; i++) step(1, 16'h1000 + 16'(i), 1, m_pc + 16'd1);
    check("seq_fetch_cnt", 32'(fetch_cnt), 32'(4));
    check("seq_pc", 32'(pc_i), 32'(4));

    // Three wait cycles, then the ack.
    for (int i = 0; i < 3; i++) step(0, 16'hFFFF, 1, m_pc + 16'd1);
    step(1, 16'hA5C3, 0, m_pc + 16'd1);
    check("dly_instr_o", 32'(instr_o), 32'hA5C3);

    // Decode stalls ten cycles; a stray ack must not disturb anything.
    for (int i = 0; i < 10; i++) step(i == 5, 16'h5A5A, 0, m_pc + 16'd1);
    check("stall_instr_o", 32'(instr_o), 32'hA5C3);
    check("stall_valid", 32'(instr_valid), 32'(1));
    step(0, 16'h0, 1, m_pc + 16'd1);

    // No ack for TIMEOUT cycles: abort (late ack ignored), then retry.
    for (int i = 0; i < TB_TIMEOUT; i++) step(0, 16'h0, 0, m_pc + 16'd1);
    step(1, 16'hDEAD, 0, m_pc + 16'd1);
    step(1, 16'h1234, 0, m_pc + 16'd1);
    step(0, 16'h0, 1, m_pc + 16'd1);
    check("abort_cnt", 32'(fetch_cnt), 32'(6));

    // Reset in the middle of a wait.
    step(0, 16'h0, 0, m_pc + 16'd1);
    step(0, 16'h0, 0, m_pc + 16'd1);
    CLR = 1'b1;
    #1;
    check_reset();
    @(negedge CLK);
    CLR = 1'b0;
    model_reset();
    step(0, 16'h0, 1, m_pc + 16'd1);
    #1;
    check("post_rst_req", 32'(bus.mem_req), 32'(1));

    // Seventeen instructions through a 4-bit counter.
    for (int i = 0; i < 34; i++) step(1, 16'(i), 1, m_pc + 16'd1);
    check("wrap_cnt", 32'(fetch_cnt), 32'(1));

    // Random traffic with jumps, stalls and timeouts.
    for (int i = 0; i < 400; i++) begin
      logic ack, rdy;
      logic [15:0] npc;
      ack = ($urandom_range(0, 9) < 4);
      rdy = ($urandom_range(0, 2) != 0);
      npc = ($urandom_range(0, 3) == 0) ? 16'($urandom) : m_pc + 16'd1;
      step(ack, 16'($urandom), rdy, npc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
